// File: rtl/biriscv_v_writeback.sv
// Vector writeback stage.
// Buffers ALU results in a 2-entry in-order FIFO, presents the head to the
// vector register file write port, and tracks which vector registers have
// an issued result still waiting to be written back.
module biriscv_v_writeback #(
  parameter int unsigned VLEN = 128,
  parameter int unsigned ELEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            alu_valid_i,
  input  logic [4:0]      alu_vd_idx_i,
  input  logic [VLEN-1:0] alu_value_i,
  output logic            alu_accept_o,
  input  logic            issue_valid_i,
  input  logic [4:0]      issue_vd_idx_i,
  output logic            vrf_wr_en_o,
  output logic [4:0]      vrf_wr_idx_o,
  output logic [VLEN-1:0] vrf_wr_data_o,
  input  logic            vrf_wr_ready_i,
  output logic [31:0]     pending_o,
  output logic [1:0]      occupancy_o
);

  localparam int unsigned NumLanes = VLEN / ELEN;

  logic [4:0]      idxStore_q  [2];
  logic [VLEN-1:0] dataStore_q [2];
  logic            wrPtr_q, wrPtr_d;
  logic            rdPtr_q, rdPtr_d;
  logic [1:0]      count_q, count_d;
  logic [31:0]     pending_q, pending_d;
  logic            push;
  logic            pop;
  logic [VLEN-1:0] headData;

  // Accept depends only on buffer fullness so upstream never waits on the VRF.
  assign alu_accept_o = (count_q < 2'd2);
  assign push         = alu_valid_i & alu_accept_o;
  assign vrf_wr_en_o  = (count_q != 2'd0);
  assign pop          = vrf_wr_en_o & vrf_wr_ready_i;

  assign vrf_wr_idx_o = idxStore_q[rdPtr_q];
  assign headData     = dataStore_q[rdPtr_q];
  assign occupancy_o  = count_q;
  assign pending_o    = pending_q;

  // Data passes through untouched, lane by lane, with no masking.
  for (genvar lane = 0; lane < NumLanes; lane++) begin : gLane
    assign vrf_wr_data_o[lane*ELEN +: ELEN] = headData[lane*ELEN +: ELEN];
  end

  // Next-state for pointers, occupancy and the pending scoreboard; a new
  // issue to the same register overrides the clear from a retiring write.
  always_comb begin
    wrPtr_d   = wrPtr_q ^ push;
    rdPtr_d   = rdPtr_q ^ pop;
    count_d   = count_q;
    pending_d = pending_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    if (pop) begin
      pending_d[vrf_wr_idx_o] = 1'b0;
    end
    if (issue_valid_i) begin
      pending_d[issue_vd_idx_i] = 1'b1;
    end
  end

  // Control state; reset discards any buffered results.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wrPtr_q   <= 1'b0;
      rdPtr_q   <= 1'b0;
      count_q   <= 2'd0;
      pending_q <= 32'd0;
    end else begin
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      count_q   <= count_d;
      pending_q <= pending_d;
    end
  end

  // Entry storage; cleared on reset so the write port shows zeros.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 2; i++) begin
        idxStore_q[i]  <= 5'd0;
        dataStore_q[i] <= '0;
      end
    end else if (push) begin
      idxStore_q[wrPtr_q]  <= alu_vd_idx_i;
      dataStore_q[wrPtr_q] <= alu_value_i;
    end
  end

endmodule

// File: tb/tb_biriscv_v_writeback.sv
// Directed testbench for the vector writeback stage.
module tb_biriscv_v_writeback;

  logic         clk;
  logic         rst;
  logic         aluValid;
  logic [4:0]   aluIdx;
  logic [127:0] aluValue;
  logic         aluAccept;
  logic         issueValid;
  logic [4:0]   issueIdx;
  logic         wrEn;
  logic [4:0]   wrIdx;
  logic [127:0] wrData;
  logic         wrReady;
  logic [31:0]  pending;
  logic [1:0]   occupancy;

  int errCount;
  int checkCount;

  localparam logic [127:0] ValA = 128'h0000_0004_0000_0003_0000_0002_0000_0001;
  localparam logic [127:0] ValB = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_FEDC_BA98;
  localparam logic [127:0] ValC = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [127:0] ValD = 128'hA5A5_A5A5_5A5A_5A5A_0F0F_0F0F_F0F0_F0F0;
  localparam logic [127:0] ValE = 128'h8000_0000_0000_0000_0000_0000_0000_0001;
  localparam logic [127:0] ValF = 128'hCAFE_F00D_0000_0009_1234_5678_9ABC_DEF0;

  biriscv_v_writeback dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .alu_valid_i    (aluValid),
    .alu_vd_idx_i   (aluIdx),
    .alu_value_i    (aluValue),
    .alu_accept_o   (aluAccept),
    .issue_valid_i  (issueValid),
    .issue_vd_idx_i (issueIdx),
    .vrf_wr_en_o    (wrEn),
    .vrf_wr_idx_o   (wrIdx),
    .vrf_wr_data_o  (wrData),
    .vrf_wr_ready_i (wrReady),
    .pending_o      (pending),
    .occupancy_o    (occupancy)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle's worth of inputs, then let combinational outputs settle.
  task automatic applyStimulus(input logic av, input logic [4:0] ai, input logic [127:0] aval,
                               input logic iv, input logic [4:0] ii, input logic rdy);
    aluValid   = av;
    aluIdx     = ai;
    aluValue   = aval;
    issueValid = iv;
    issueIdx   = ii;
    wrReady    = rdy;
    #1;
  endtask

  // Advance past the next rising edge and sample midway through the low phase.
  task automatic nextCycle();
    @(negedge clk);
    #1;
  endtask

  // Single comparison point: counts and reports mismatches.
  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Directed scenarios.
  initial begin
    errCount   = 0;
    checkCount = 0;
    rst        = 1'b1;
    applyStimulus(1'b0, 5'd0, '0, 1'b0, 5'd0, 1'b0);
    nextCycle();

    checkOutput("reset occupancy", 128'(occupancy), 128'd0);
    checkOutput("reset accept",    128'(aluAccept), 128'd1);
    checkOutput("reset wr_en",     128'(wrEn),      128'd0);
    checkOutput("reset wr_idx",    128'(wrIdx),     128'd0);
    checkOutput("reset wr_data",   wrData,          128'd0);
    checkOutput("reset pending",   128'(pending),   128'd0);
    rst = 1'b0;

    // Issue v5, push its result, watch it write back and retire.
    applyStimulus(1'b0, 5'd0, '0, 1'b1, 5'd5, 1'b1);
    nextCycle();
    checkOutput("t1 pending after issue", 128'(pending), 128'h20);
    applyStimulus(1'b1, 5'd5, ValA, 1'b0, 5'd0, 1'b1);
    checkOutput("t1 accept", 128'(aluAccept), 128'd1);
    checkOutput("t1 no bypass", 128'(wrEn), 128'd0);
    nextCycle();
    applyStimulus(1'b0, 5'd0, '0, 1'b0, 5'd0, 1'b1);
    checkOutput("t1 wr_en", 128'(wrEn), 128'd1);
    checkOutput("t1 wr_idx", 128'(wrIdx), 128'd5);
    checkOutput("t1 wr_data", wrData, ValA);
    checkOutput("t1 pending held", 128'(pending), 128'h20);
    nextCycle();
    checkOutput("t1 pending cleared", 128'(pending), 128'd0);
    checkOutput("t1 occupancy", 128'(occupancy), 128'd0);
    checkOutput("t1 wr_en idle", 128'(wrEn), 128'd0);

    // Fill while the VRF stalls, drop the overflow push, then drain in order.
    applyStimulus(1'b1, 5'd1, ValB, 1'b0, 5'd0, 1'b0);
    nextCycle();
    applyStimulus(1'b1, 5'd2, ValC, 1'b0, 5'd0, 1'b0);
    nextCycle();
    applyStimulus(1'b1, 5'd3, ValD, 1'b0, 5'd0, 1'b0);
    checkOutput("t2 occupancy full", 128'(occupancy), 128'd2);
    checkOutput("t2 accept full", 128'(aluAccept), 128'd0);
    nextCycle();
    applyStimulus(1'b0, 5'd0, '0, 1'b0, 5'd0, 1'b0);
    checkOutput("t2 occupancy after drop", 128'(occupancy), 128'd2);
    checkOutput("t2 head stable idx", 128'(wrIdx), 128'd1);
    checkOutput("t2 head stable data", wrData, ValB);
    nextCycle();
    applyStimulus(1'b0, 5'd0, '0, 1'b0, 5'd0, 1'b1);
    checkOutput("t2 accept ignores ready", 128'(aluAccept), 128'd0);
    checkOutput("t2 first write idx", 128'(wrIdx), 128'd1);
    nextCycle();
    checkOutput("t2 second write en", 128'(wrEn), 128'd1);
    checkOutput("t2 second write idx", 128'(wrIdx), 128'd2);
    checkOutput("t2 second write data", wrData, ValC);
    checkOutput("t2 occupancy one", 128'(occupancy), 128'd1);
    nextCycle();
    checkOutput("t2 drained", 128'(occupancy), 128'd0);

    // Push and pop together at occupancy 1.
    applyStimulus(1'b1, 5'd7, ValD, 1'b0, 5'd0, 1'b0);
    nextCycle();
    checkOutput("t3 head idx 7", 128'(wrIdx), 128'd7);
    applyStimulus(1'b1, 5'd8, ValE, 1'b0, 5'd0, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 5'd0, '0, 1'b0, 5'd0, 1'b1);
    checkOutput("t3 occupancy kept", 128'(occupancy), 128'd1);
    checkOutput("t3 head idx 8", 128'(wrIdx), 128'd8);
    checkOutput("t3 head data", wrData, ValE);
    nextCycle();
    checkOutput("t3 drained", 128'(occupancy), 128'd0);

    // A re-issue of v4 wins against the retiring write of v4.
    applyStimulus(1'b0, 5'd0, '0, 1'b1, 5'd4, 1'b1);
    nextCycle();
    applyStimulus(1'b1, 5'd4, ValC, 1'b0, 5'd0, 1'b0);
    nextCycle();
    checkOutput("t4 pending set", 128'(pending), 128'h10);
    applyStimulus(1'b0, 5'd0, '0, 1'b1, 5'd4, 1'b1);
    nextCycle();
    checkOutput("t4 set wins", 128'(pending), 128'h10);
    checkOutput("t4 popped", 128'(occupancy), 128'd0);
    applyStimulus(1'b1, 5'd4, ValC, 1'b0, 5'd0, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 5'd0, '0, 1'b0, 5'd0, 1'b1);
    nextCycle();
    checkOutput("t4 pending cleared", 128'(pending), 128'd0);

    // Reset mid-cycle with a full buffer and pending bits.
    applyStimulus(1'b1, 5'd1, ValA, 1'b1, 5'd1, 1'b0);
    nextCycle();
    applyStimulus(1'b1, 5'd2, ValB, 1'b1, 5'd2, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 5'd0, '0, 1'b0, 5'd0, 1'b0);
    checkOutput("t5 occupancy full", 128'(occupancy), 128'd2);
    checkOutput("t5 pending", 128'(pending), 128'h6);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("t5 rst occupancy", 128'(occupancy), 128'd0);
    checkOutput("t5 rst wr_en", 128'(wrEn), 128'd0);
    checkOutput("t5 rst wr_idx", 128'(wrIdx), 128'd0);
    checkOutput("t5 rst wr_data", wrData, 128'd0);
    checkOutput("t5 rst pending", 128'(pending), 128'd0);
    checkOutput("t5 rst accept", 128'(aluAccept), 128'd1);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b1, 5'd9, ValF, 1'b0, 5'd0, 1'b0);
    checkOutput("t5 no bypass", 128'(wrEn), 128'd0);
    nextCycle();
    applyStimulus(1'b0, 5'd0, '0, 1'b0, 5'd0, 1'b0);
    checkOutput("t5 post-reset wr_en", 128'(wrEn), 128'd1);
    checkOutput("t5 post-reset wr_idx", 128'(wrIdx), 128'd9);
    checkOutput("t5 post-reset wr_data", wrData, ValF);
    checkOutput("t5 post-reset occupancy", 128'(occupancy), 128'd1);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule

// File: doc/biriscv_v_writeback.md
BIRISCV_V_WRITEBACK -- requirements
Module: biriscv_v_writeback

Interface
REQ-001 Parameter VLEN, default 128, vector register width in bits.
REQ-002 Parameter ELEN, default 32, element width in bits; VLEN SHALL be a multiple of ELEN.
REQ-003 clk_i  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 rst_i  input  1  reset, asynchronous and active-high.
REQ-005 alu_valid_i  input  1  ALU result valid this cycle.
REQ-006 alu_vd_idx_i  input  5  destination vector register of the ALU result.
REQ-007 alu_value_i  input  VLEN  ALU result vector.
REQ-008 alu_accept_o  output  1  stage can take an ALU result this cycle.
REQ-009 issue_valid_i  input  1  a vector ALU op is being issued this cycle.
REQ-010 issue_vd_idx_i  input  5  destination register of the issued op.
REQ-011 vrf_wr_en_o  output  1  vector register file write request.
REQ-012 vrf_wr_idx_o  output  5  register index being written.
REQ-013 vrf_wr_data_o  output  VLEN  data being written.
REQ-014 vrf_wr_ready_i  input  1  register file grants the write port this cycle.
REQ-015 pending_o  output  32  bit n set: register vn has an issued but unwritten result.
REQ-016 occupancy_o  output  2  number of buffered results (0..2).

Function
REQ-017 The block SHALL hold ALU results in a 2-entry in-order FIFO (index plus data per entry).
REQ-018 alu_accept_o SHALL be 1 exactly when occupancy_o < 2; it SHALL NOT depend on vrf_wr_ready_i.
REQ-019 A push SHALL occur when alu_valid_i and alu_accept_o are both 1; alu_valid_i while alu_accept_o is 0 SHALL be ignored.
REQ-020 vrf_wr_en_o SHALL be 1 exactly when occupancy_o != 0; vrf_wr_idx_o/vrf_wr_data_o SHALL show the FIFO head, driven from registers.
REQ-021 A pop SHALL occur when vrf_wr_en_o and vrf_wr_ready_i are both 1.
REQ-022 Head index/data SHALL stay stable while vrf_wr_en_o is 1 and vrf_wr_ready_i is 0.
REQ-023 Latency: a result pushed in cycle N into an empty FIFO SHALL appear on vrf_wr_* in cycle N+1; there SHALL be no same-cycle bypass.
REQ-024 Simultaneous push and pop with occupancy 1 SHALL leave occupancy 1, with the new entry becoming the head.
REQ-025 Simultaneous push and pop with occupancy 0 cannot occur; with occupancy 2 the push is blocked by REQ-018.
REQ-026 Occupancy SHALL move +1 on push only, -1 on pop only, and stay unchanged on both or neither.
REQ-027 Read and write pointers SHALL be 1-bit and wrap 1->0.
REQ-028 pending_o bit issue_vd_idx_i SHALL be set on the cycle after issue_valid_i is 1.
REQ-029 pending_o bit vrf_wr_idx_o SHALL be cleared on the cycle after a pop.
REQ-030 If a set and a clear target the same bit in one cycle, set SHALL win (a newer producer of the same vd).
REQ-031 The block SHALL treat data opaquely: no element masking, no width change, VLEN bits in and VLEN bits out.

Reset
REQ-032 While rst_i is 1, the following SHALL hold asynchronously, including mid-transfer; any buffered entries SHALL be discarded:
- occupancy_o = 0, pointers = 0
- vrf_wr_en_o = 0, vrf_wr_idx_o = 0, vrf_wr_data_o = 0
- pending_o = 0
- alu_accept_o = 1
REQ-033 The first push SHALL be accepted in the first rising edge after rst_i deasserts.

Verification
REQ-034 Issue v5, then push vd=5 value=128'h0000_0004_0000_0003_0000_0002_0000_0001 with vrf_wr_ready_i=1 -> pending_o[5]=1; the next cycle vrf_wr_en_o=1, idx=5, data matches; the cycle after, pending_o[5]=0 and occupancy_o=0.
REQ-035 vrf_wr_ready_i=0; push vd=1, vd=2, then attempt vd=3 -> occupancy_o=2, alu_accept_o=0, vd=3 dropped; raise ready -> writes of idx 1 then 2 on consecutive cycles.
REQ-036 Occupancy 1 (head vd=7), push vd=8 and ready=1 in the same cycle -> occupancy stays 1; next head idx=8.
REQ-037 pending_o[4]=1 with head vd=4 popping while issue_valid_i=1, issue_vd_idx_i=4 in the same cycle -> pending_o[4] remains 1.
REQ-038 Occupancy 2 and pending_o=32'h0000_0006, assert rst_i mid-cycle -> outputs immediately 0, alu_accept_o=1; after release, a push of vd=9 appears on vrf_wr_* one cycle later.
